// File: rtl/audio_frame_sync_fifo.sv
// audio_frame_sync_fifo: brings I2S frames into the Clk domain and buffers them as L/R samples; AUD_FIFO_OVF_CNT_EN enables the drop counter
module audio_frame_sync_fifo #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    Reci_Done,
    input  logic [31:0]             Reci_Data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_left,
    output logic [15:0]             out_right,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    ovf_flag,
    output logic [15:0]             ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, PUSH} state_t;

    state_t          state;
    logic            s1, s2, s3;
    logic [3:0]      cnt;
    logic [PW-1:0]   wptr, rptr;
    logic [31:0]     mem [DEPTH];
    logic            fall_evt, full, pop, push, drop, miss;

    assign fall_evt  = s3 & ~s2;
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign out_valid = wptr != rptr;
    assign pop       = out_valid & out_ready;
    assign push      = (state == PUSH) & (~full | pop);
    assign drop      = (state == PUSH) & full & ~pop;
    assign miss      = fall_evt & (state != IDLE);
    assign out_left  = out_valid ? mem[rptr[AW-1:0]][31:16] : '0;
    assign out_right = out_valid ? mem[rptr[AW-1:0]][15:0] : '0;

    // three-flop strobe synchronizer; s3 is the delayed copy for edge detection
    always_ff @(posedge Clk) begin
        if (reset) {s3, s2, s1} <= '0;
        else       {s3, s2, s1} <= {s2, s1, Reci_Done};
    end

    // capture sequencer: wait for the data word to settle, then push once
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (fall_evt) begin
                    state <= SETTLE;
                    cnt   <= 4'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd0) ? PUSH : SETTLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and registered occupancy
    always_ff @(posedge Clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fill_level <= '0;
        end else begin
            wptr       <= wptr + PW'(push);
            rptr       <= rptr + PW'(pop);
            fill_level <= fill_level + PW'(push) - PW'(pop);
        end
    end

    // storage array; contents are masked by out_valid so no reset is needed
    always_ff @(posedge Clk) begin
        if (push) mem[wptr[AW-1:0]] <= {Reci_Data[31:16], Reci_Data[15:0]};
    end

    // sticky overflow: dropped frame or strobe arriving while busy
    always_ff @(posedge Clk) begin
        if (reset)            ovf_flag <= 1'b0;
        else if (drop | miss) ovf_flag <= 1'b1;
    end

`ifdef AUD_FIFO_OVF_CNT_EN
    // saturating count of lost frames; coincident events count once
    always_ff @(posedge Clk) begin
        if (reset)                                   ovf_count <= '0;
        else if ((drop | miss) && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end
`else
    assign ovf_count = 16'h0000;
`endif
endmodule

// File: tb/tb_audio_frame_sync_fifo.sv
// tb_audio_frame_sync_fifo: directed self-checking bench for audio_frame_sync_fifo
module tb_audio_frame_sync_fifo;
    logic        Clk = 0;
    logic        reset = 1;
    logic        Reci_Done = 0;
    logic [31:0] Reci_Data = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_left, out_right;
    logic [2:0]  fill_level;
    logic        ovf_flag;
    logic [15:0] ovf_count;
    int          tests = 0;
    int          fails = 0;

`ifdef AUD_FIFO_OVF_CNT_EN
    localparam logic [15:0] CNT1 = 16'd1;
`else
    localparam logic [15:0] CNT1 = 16'd0;
`endif

    audio_frame_sync_fifo dut (
        .Clk(Clk), .reset(reset), .Reci_Done(Reci_Done), .Reci_Data(Reci_Data),
        .out_valid(out_valid), .out_ready(out_ready), .out_left(out_left),
        .out_right(out_right), .fill_level(fill_level), .ovf_flag(ovf_flag),
        .ovf_count(ovf_count)
    );

    always #10 Clk = ~Clk;

    task automatic do_reset();
        @(negedge Clk) reset = 1;
        repeat (3) @(negedge Clk);
        reset = 0;
    endtask

    task automatic frame(input logic [31:0] d);
        @(negedge Clk) Reci_Done = 1;
        repeat (4) @(negedge Clk);
        Reci_Done = 0;
        Reci_Data = d;
    endtask

    task automatic pop1();
        @(negedge Clk) out_ready = 1;
        @(negedge Clk) out_ready = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests++; if (fill_level !== 3'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        tests++; if ({out_left, out_right} !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {out_left, out_right}); end
        tests++; if (ovf_flag !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf_flag); end
        tests++; if (ovf_count !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0", ovf_count); end
    endtask

    task automatic test_single();
        int n = 0;
        frame(32'h1234_ABCD);
        while (n < 20) begin
            @(negedge Clk) n++;
            if (out_valid === 1'b1) break;
        end
        tests++; if (n < 5 || n > 7) begin fails++; $display("FAIL single_latency: got %0d want 6+-1", n); end
        tests++; if (out_left !== 16'h1234) begin fails++; $display("FAIL single_left: got %h want 1234", out_left); end
        tests++; if (out_right !== 16'hABCD) begin fails++; $display("FAIL single_right: got %h want abcd", out_right); end
        tests++; if (fill_level !== 3'd1) begin fails++; $display("FAIL single_fill: got %0d want 1", fill_level); end
        pop1();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_fill_ovf();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            frame({16'(i), 16'(i)});
            repeat (10) @(negedge Clk);
        end
        tests++; if (fill_level !== 3'd4) begin fails++; $display("FAIL ovf_fill: got %0d want 4", fill_level); end
        tests++; if (ovf_flag !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", ovf_flag); end
        tests++; if (ovf_count !== CNT1) begin fails++; $display("FAIL ovf_count: got %h want %h", ovf_count, CNT1); end
        for (int i = 1; i <= 4; i++) begin
            tests++; if (out_valid !== 1'b1 || out_left !== 16'(i) || out_right !== 16'(i)) begin
                fails++; $display("FAIL drain_%0d: got v=%b %h/%h want 1 %h/%h", i, out_valid, out_left, out_right, 16'(i), 16'(i));
            end
            pop1();
        end
        tests++; if (out_valid !== 1'b0 || fill_level !== 3'd0) begin fails++; $display("FAIL drain_empty: got v=%b fill=%0d want 0 0", out_valid, fill_level); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            frame({16'(16'h0010 + i), 16'(16'h0020 + i)});
            repeat (10) @(negedge Clk);
        end
        frame(32'h0055_0066);
        repeat (5) @(negedge Clk);
        out_ready = 1;
        @(negedge Clk) out_ready = 0;
        tests++; if (fill_level !== 3'd4) begin fails++; $display("FAIL ppf_fill: got %0d want 4", fill_level); end
        tests++; if (ovf_flag !== 1'b0) begin fails++; $display("FAIL ppf_ovf: got %b want 0", ovf_flag); end
        for (int i = 2; i <= 5; i++) begin
            logic [31:0] e;
            e = (i == 5) ? 32'h0055_0066 : {16'(16'h0010 + i), 16'(16'h0020 + i)};
            tests++; if ({out_left, out_right} !== e) begin fails++; $display("FAIL ppf_order_%0d: got %h want %h", i, {out_left, out_right}, e); end
            pop1();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] e;
            logic        got;
            e = {16'(i + 1), 16'(16'hC000 + i)};
            got = 0;
            frame(e);
            for (int k = 0; k < 12; k++) begin
                @(negedge Clk);
                if (out_valid === 1'b1 && !got) begin
                    got = 1;
                    tests++; if ({out_left, out_right} !== e) begin fails++; $display("FAIL wrap_%0d: got %h want %h", i, {out_left, out_right}, e); end
                end
            end
            tests++; if (!got) begin fails++; $display("FAIL wrap_timeout_%0d: got none want %h", i, e); end
        end
        out_ready = 0;
        tests++; if (ovf_flag !== 1'b0) begin fails++; $display("FAIL wrap_ovf: got %b want 0", ovf_flag); end
        tests++; if (fill_level !== 3'd0) begin fails++; $display("FAIL wrap_fill: got %0d want 0", fill_level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame(32'h0A0A_0B0B); repeat (10) @(negedge Clk);
        frame(32'h0C0C_0D0D); repeat (10) @(negedge Clk);
        tests++; if (fill_level !== 3'd2) begin fails++; $display("FAIL mid_pre_fill: got %0d want 2", fill_level); end
        frame(32'h0E0E_0F0F);
        repeat (3) @(negedge Clk);
        reset = 1;
        @(negedge Clk);
        tests++; if (out_valid !== 1'b0 || fill_level !== 3'd0) begin fails++; $display("FAIL mid_state: got v=%b fill=%0d want 0 0", out_valid, fill_level); end
        tests++; if ({out_left, out_right} !== 32'h0 || ovf_flag !== 1'b0) begin fails++; $display("FAIL mid_data: got %h ovf=%b want 0 0", {out_left, out_right}, ovf_flag); end
        reset = 0;
        repeat (10) @(negedge Clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_discard: got %b want 0", out_valid); end
        frame(32'h7FFF_8000); repeat (10) @(negedge Clk);
        tests++; if ({out_left, out_right} !== 32'h7FFF_8000 || fill_level !== 3'd1) begin fails++; $display("FAIL mid_next: got %h fill=%0d want 7fff8000 1", {out_left, out_right}, fill_level); end
    endtask

    task automatic test_early();
        do_reset();
        frame(32'h4444_5555);
        @(negedge Clk) Reci_Done = 1;
        @(negedge Clk) Reci_Done = 0;
        repeat (12) @(negedge Clk);
        tests++; if (fill_level !== 3'd1) begin fails++; $display("FAIL early_fill: got %0d want 1", fill_level); end
        tests++; if (ovf_flag !== 1'b1) begin fails++; $display("FAIL early_ovf: got %b want 1", ovf_flag); end
        tests++; if (ovf_count !== CNT1) begin fails++; $display("FAIL early_cnt: got %h want %h", ovf_count, CNT1); end
        tests++; if ({out_left, out_right} !== 32'h4444_5555) begin fails++; $display("FAIL early_data: got %h want 44445555", {out_left, out_right}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_ovf();
        test_push_pop_full();
        test_wrap();
        test_reset_mid();
        test_early();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
